// File: rtl/syn_fgyrus_pkg.sv
// Shared types for the Fusiform Gyrus FFT butterfly scheduler.
package syn_fgyrus_pkg;

    localparam int unsigned FFT_N_W   = 8;
    localparam int unsigned FFT_STG_W = $clog2(FFT_N_W);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fsm_state_e;

    typedef struct packed {
        logic [FFT_N_W-1:0]   addr_a;
        logic [FFT_N_W-1:0]   addr_b;
        logic [FFT_N_W-2:0]   twdl;
        logic [FFT_STG_W-1:0] stage;
        logic                 last;
    } bfly_desc_t;

endpackage

// File: rtl/syn_fgyrus_bfly_addr_gen.sv
// Registered map from (stage, butterfly index) to cache A/B addresses and twiddle index.
module syn_fgyrus_bfly_addr_gen
    import syn_fgyrus_pkg::*;
(
    input  logic                 clk_ir,
    input  logic                 clr,
    input  logic                 ld,
    input  logic [FFT_STG_W-1:0] stage,
    input  logic [FFT_N_W-2:0]   k,
    output bfly_desc_t           desc
);

    localparam int unsigned W    = FFT_N_W;
    localparam int unsigned SW   = FFT_STG_W;
    localparam int unsigned SW1  = FFT_STG_W + 1;
    localparam int unsigned TW_W = FFT_N_W - 1;

    logic [W-1:0]   k_ext;
    logic [W-1:0]   span;
    logic [W-1:0]   grp;
    logic [W-1:0]   pos;
    logic [W-1:0]   addr_a_c;
    logic [SW1-1:0] sh_a;
    logic [SW-1:0]  sh_tw;
    bfly_desc_t     desc_c;

    // Group/position split of k, then spread groups apart by twice the span.
    always_comb begin
        k_ext    = W'(k);
        span     = W'(1) << stage;
        grp      = k_ext >> stage;
        pos      = k_ext & (span - W'(1));
        sh_a     = SW1'(stage) + SW1'(1);
        sh_tw    = SW'(W - 1) - stage;
        addr_a_c = (grp << sh_a) | pos;

        desc_c        = '0;
        desc_c.addr_a = addr_a_c;
        desc_c.addr_b = addr_a_c + span;
        desc_c.twdl   = TW_W'(pos << sh_tw);
        desc_c.stage  = stage;
        desc_c.last   = &k;
    end

    always_ff @(posedge clk_ir) begin
        if (clr) begin
            desc <= '0;
        end else if (ld) begin
            desc <= desc_c;
        end
    end

endmodule

// File: rtl/syn_fgyrus_but_sched.sv
// Butterfly scheduler: sequences FFT stages/butterflies over a valid/ready link
// and holds each stage boundary until all in-flight write-backs have landed.
module syn_fgyrus_but_sched
    import syn_fgyrus_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES_W = FFT_N_W,
    parameter int unsigned MAX_OUTSTD    = 8
) (
    input  logic                             clk_ir,
    input  logic                             rst_sync,
    input  logic                             start_i,
    input  logic                             abort_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             bfly_valid_o,
    input  logic                             bfly_rdy_i,
    output logic [NUM_SAMPLES_W-1:0]         addr_a_o,
    output logic [NUM_SAMPLES_W-1:0]         addr_b_o,
    output logic [NUM_SAMPLES_W-2:0]         twdl_addr_o,
    output logic [$clog2(NUM_SAMPLES_W)-1:0] stage_o,
    output logic                             last_o,
    input  logic                             wb_ack_i,
    output logic                             err_o
);

    localparam int unsigned STG_W = $clog2(NUM_SAMPLES_W);
    localparam int unsigned K_W   = NUM_SAMPLES_W - 1;
    localparam int unsigned OST_W = $clog2(MAX_OUTSTD) + 1;
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_SAMPLES_W - 1);
    localparam logic [OST_W-1:0] OST_MAX    = OST_W'(MAX_OUTSTD);

    fsm_state_e        state_q, state_n;
    logic [STG_W-1:0]  stage_q, stage_n;
    logic [K_W-1:0]    k_q, k_n;
    logic [OST_W-1:0]  ost_q, ost_n;
    logic              valid_q, valid_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
    logic              hs;
    logic              ack_ok;
    logic              ld;
    bfly_desc_t        desc;

    syn_fgyrus_bfly_addr_gen u_addr_gen (
        .clk_ir (clk_ir),
        .clr    (rst_sync | abort_i),
        .ld     (ld),
        .stage  (stage_n),
        .k      (k_n),
        .desc   (desc)
    );

    // Next-state, issue gating and in-flight accounting.
    always_comb begin
        state_n = state_q;
        stage_n = stage_q;
        k_n     = k_q;
        valid_n = valid_q;
        ld      = 1'b0;
        hs      = valid_q & bfly_rdy_i;
        ack_ok  = wb_ack_i && (ost_q != '0);
        err_n   = wb_ack_i && (ost_q == '0);
        ost_n   = ost_q + OST_W'(hs) - OST_W'(ack_ok);

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_n = ISSUE;
                    stage_n = '0;
                    k_n     = '0;
                    ld      = 1'b1;
                    valid_n = 1'b1;
                end
            end
            ISSUE: begin
                if (hs) begin
                    if (&k_q) begin
                        state_n = DRAIN;
                        valid_n = 1'b0;
                    end else begin
                        k_n     = k_q + K_W'(1);
                        ld      = 1'b1;
                        valid_n = (ost_n < OST_MAX);
                    end
                end else if (!valid_q) begin
                    valid_n = (ost_n < OST_MAX);
                end
            end
            DRAIN: begin
                if (ost_q == '0) begin
                    if (stage_q == LAST_STAGE) begin
                        state_n = DONE;
                    end else begin
                        state_n = ISSUE;
                        stage_n = stage_q + STG_W'(1);
                        k_n     = '0;
                        ld      = 1'b1;
                        valid_n = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort wins over everything issued or accepted this cycle.
        if (abort_i) begin
            state_n = IDLE;
            stage_n = '0;
            k_n     = '0;
            valid_n = 1'b0;
            ost_n   = '0;
            err_n   = 1'b0;
            ld      = 1'b0;
        end

        busy_n = (state_n == ISSUE) || (state_n == DRAIN);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            state_q <= IDLE;
            stage_q <= '0;
            k_q     <= '0;
            ost_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            stage_q <= stage_n;
            k_q     <= k_n;
            ost_q   <= ost_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign bfly_valid_o = valid_q;
    assign addr_a_o     = desc.addr_a;
    assign addr_b_o     = desc.addr_b;
    assign twdl_addr_o  = desc.twdl;
    assign stage_o      = desc.stage;
    assign last_o       = desc.last;

endmodule

// File: tb/tb_syn_fgyrus_but_sched.sv
// Scoreboard bench for the FFT butterfly scheduler.
`timescale 1ns/1ps
module tb_syn_fgyrus_but_sched;

    localparam int NB = 128;
    localparam int NS = 8;

    logic       clk_ir = 1'b0;
    logic       rst_sync, start_i, abort_i, bfly_rdy_i, wb_ack_i;
    logic       busy_o, done_o, bfly_valid_o, last_o, err_o;
    logic [7:0] addr_a_o, addr_b_o;
    logic [6:0] twdl_addr_o;
    logic [2:0] stage_o;

    syn_fgyrus_but_sched dut (
        .clk_ir       (clk_ir),
        .rst_sync     (rst_sync),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .bfly_valid_o (bfly_valid_o),
        .bfly_rdy_i   (bfly_rdy_i),
        .addr_a_o     (addr_a_o),
        .addr_b_o     (addr_b_o),
        .twdl_addr_o  (twdl_addr_o),
        .stage_o      (stage_o),
        .last_o       (last_o),
        .wb_ack_i     (wb_ack_i),
        .err_o        (err_o)
    );

    always #5 clk_ir = ~clk_ir;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: group = k/span, pos = k%span, A = group*2*span+pos, twiddle = pos*(N/2/span).
    function automatic logic [31:0] model(input int s, input int k);
        int span, grp, pos, a, b, tw;
        span = 2 ** s;
        grp  = k / span;
        pos  = k % span;
        a    = grp * 2 * span + pos;
        b    = a + span;
        tw   = pos * (NB / span);
        return {5'd0, 8'(a), 8'(b), 7'(tw), 3'(s), (k == NB - 1)};
    endfunction

    function automatic logic [31:0] obs();
        return {5'd0, addr_a_o, addr_b_o, twdl_addr_o, stage_o, last_o};
    endfunction

    logic [31:0] exp_q[$];
    int          ack_q[$];
    int          cyc = 0;
    bit          ack_auto = 0;
    int          ack_dly = 3;
    bit          man_ack = 0;
    int          rdy_mode = 0;
    int          rdy_budget = 0;

    // Ready and write-back acknowledge driver.
    initial begin
        wb_ack_i   = 1'b0;
        bfly_rdy_i = 1'b0;
        forever begin
            @(posedge clk_ir);
            cyc++;
            #2;
            while (ack_q.size() > 0 && ack_q[0] < cyc) void'(ack_q.pop_front());
            wb_ack_i = man_ack;
            if (ack_q.size() > 0 && ack_q[0] == cyc) begin
                void'(ack_q.pop_front());
                wb_ack_i = 1'b1;
            end
            case (rdy_mode)
                0:       bfly_rdy_i = 1'b0;
                1:       bfly_rdy_i = 1'b1;
                2:       bfly_rdy_i = ($urandom_range(99) < 30);
                default: bfly_rdy_i = (rdy_budget > 0);
            endcase
        end
    end

    int          hs_cnt = 0, done_cnt = 0, err_cnt = 0, tb_ost = 0, run_hs = 0;
    bit          mon_stall = 0, after_last = 0, thru_chk = 0;
    int          k0_cyc = 0;
    logic [31:0] held = '0, cap1 = '0, cap2 = '0, cap3 = '0;

    // Monitor: descriptor scoreboard, stall stability, issue gate, stage boundary.
    always @(negedge clk_ir) begin : mon
        logic [31:0] d;
        bit          hs;
        d  = obs();
        hs = bfly_valid_o && bfly_rdy_i;
        if (rst_sync) begin
            mon_stall  = 0;
            tb_ost     = 0;
            after_last = 0;
        end else begin
            if (mon_stall) begin
                chk("stall_valid", 32'(bfly_valid_o), 32'd1);
                chk("stall_hold", d, held);
            end
            if (bfly_valid_o) chk("ost_gate", 32'(tb_ost < 8), 32'd1);
            if (done_o) begin
                done_cnt++;
                chk("done_busy", 32'(busy_o), 32'd0);
                chk("done_ost", tb_ost, 0);
            end
            if (err_o) err_cnt++;
            if (abort_i) begin
                tb_ost     = 0;
                mon_stall  = 0;
                after_last = 0;
            end else begin
                if (hs && after_last) chk("stage_wait", tb_ost, 0);
                if (wb_ack_i && tb_ost > 0) tb_ost--;
                if (hs) begin
                    if (exp_q.size() == 0) chk("desc_extra", 0, 1);
                    else chk($sformatf("desc%0d", run_hs), d, exp_q.pop_front());
                    if (run_hs == 0 || after_last) k0_cyc = cyc;
                    if (thru_chk && last_o) chk("thru", cyc - k0_cyc, NB - 1);
                    if (run_hs == 1) cap1 = d;
                    if (run_hs == NB + 3) cap2 = d;
                    if (run_hs == 7 * NB + 5) cap3 = d;
                    tb_ost++;
                    hs_cnt++;
                    run_hs++;
                    if (rdy_budget > 0) rdy_budget--;
                    if (ack_auto) ack_q.push_back(cyc + ack_dly);
                    after_last = last_o;
                end
                mon_stall = bfly_valid_o && !bfly_rdy_i;
                held      = d;
            end
        end
    end

    task automatic start_run();
        exp_q.delete();
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < NB; k++) exp_q.push_back(model(s, k));
        run_hs = 0;
        @(posedge clk_ir); #1 start_i = 1'b1;
        @(posedge clk_ir); #1 start_i = 1'b0;
        @(negedge clk_ir);
        chk("start_lat", {30'd0, busy_o, bfly_valid_o}, 32'd3);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_ir);
            if (done_cnt != d0) break;
        end
        repeat (5) @(negedge clk_ir);
        chk({tag, "_done"}, done_cnt - d0, 1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_q"}, exp_q.size(), 0);
    endtask

    task automatic pulse_ack();
        @(posedge clk_ir); #1 man_ack = 1'b1;
        @(posedge clk_ir); #1 man_ack = 1'b0;
    endtask

    task automatic do_abort(input string tag);
        @(posedge clk_ir); #1 abort_i = 1'b1;
        @(posedge clk_ir); #1 abort_i = 1'b0;
        ack_q.delete();
        @(negedge clk_ir);
        chk({tag, "_desc"}, obs(), 32'd0);
        chk({tag, "_ctl"}, {28'd0, busy_o, done_o, bfly_valid_o, err_o}, 32'd0);
        exp_q.delete();
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int h0, d0;
        rst_sync = 1'b1;
        start_i  = 1'b0;
        abort_i  = 1'b0;
        repeat (3) @(posedge clk_ir);
        #1 rst_sync = 1'b0;
        @(negedge clk_ir);
        chk("rst_desc", obs(), 32'd0);
        chk("rst_ctl", {28'd0, busy_o, done_o, bfly_valid_o, err_o}, 32'd0);

        // Full run, ready held high, ack three cycles after each handshake
        rdy_mode = 1; ack_auto = 1; ack_dly = 3; thru_chk = 1;
        h0 = hs_cnt;
        start_run();
        wait_done("run1", 3000);
        thru_chk = 0;
        chk("run1_hs", hs_cnt - h0, NS * NB);
        chk("s0k1", cap1, {5'd0, 8'd2, 8'd3, 7'd0, 3'd0, 1'b0});
        chk("s1k3", cap2, {5'd0, 8'd5, 8'd7, 7'd64, 3'd1, 1'b0});
        chk("s7k5", cap3, {5'd0, 8'd5, 8'd133, 7'd5, 3'd7, 1'b0});
        chk("run1_err", err_cnt, 0);

        // Random backpressure
        rdy_mode = 2;
        h0 = hs_cnt;
        start_run();
        wait_done("run2", 9000);
        chk("run2_hs", hs_cnt - h0, NS * NB);

        // Throttle with write-backs withheld
        rdy_mode = 1; ack_auto = 0;
        h0 = hs_cnt;
        start_run();
        repeat (20) @(negedge clk_ir);
        chk("thr_hs8", hs_cnt - h0, 8);
        chk("thr_valid8", 32'(bfly_valid_o), 32'd0);
        pulse_ack();
        repeat (10) @(negedge clk_ir);
        chk("thr_hs9", hs_cnt - h0, 9);
        chk("thr_valid9", 32'(bfly_valid_o), 32'd0);
        do_abort("thr_abort");

        // Stray write-back while idle
        d0 = err_cnt;
        pulse_ack();
        @(negedge clk_ir);
        chk("stray_err", 32'(err_o), 32'd1);
        chk("stray_idle", {30'd0, busy_o, bfly_valid_o}, 32'd0);
        @(negedge clk_ir);
        chk("stray_pulse", err_cnt - d0, 1);

        // Abort in stage 3 with five outstanding
        rdy_mode = 1; ack_auto = 1; ack_dly = 3;
        start_run();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_ir);
            if (stage_o == 3'd3 && bfly_valid_o) break;
        end
        chk("reach_s3", 32'(stage_o), 32'd3);
        ack_auto = 0;
        rdy_mode = 0;
        repeat (10) @(negedge clk_ir);
        rdy_budget = 5 - tb_ost;
        rdy_mode = 3;
        repeat (12) @(negedge clk_ir);
        chk("pre_abort_ost", tb_ost, 5);
        d0 = done_cnt;
        do_abort("s3_abort");
        repeat (10) @(negedge clk_ir);
        chk("abort_nodone", done_cnt - d0, 0);

        // Restart from stage 0; a start pulse mid-run must be ignored
        rdy_mode = 1; ack_auto = 1; ack_dly = 3; thru_chk = 1;
        h0 = hs_cnt;
        start_run();
        repeat (300) @(posedge clk_ir);
        #1 start_i = 1'b1;
        @(posedge clk_ir);
        #1 start_i = 1'b0;
        wait_done("run4", 3000);
        thru_chk = 0;
        chk("run4_hs", hs_cnt - h0, NS * NB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
